// File: rtl/vx_hpdcache_req_sched_if.sv
// Bundle between Vortex requesters, the HPDCache core port and the scheduler.
// The scheduler takes the slave view; the environment drives through master.
interface vx_hpdcache_req_sched_if #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = 8
);
    localparam int SID_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [NUM_REQS-1:0]            req_valid_i;
    logic [NUM_REQS-1:0]            req_rw_i;
    logic [NUM_REQS-1:0]            req_flush_i;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQS*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQS*BE_W-1:0]       req_byteen_i;
    logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag_i;
    logic [NUM_REQS-1:0]            req_ready_o;

    logic                  out_req_valid_o;
    logic                  out_req_ready_i;
    logic                  out_req_rw_o;
    logic                  out_req_flush_o;
    logic [ADDR_WIDTH-1:0] out_req_addr_o;
    logic [DATA_WIDTH-1:0] out_req_data_o;
    logic [BE_W-1:0]       out_req_byteen_o;
    logic [TAG_WIDTH-1:0]  out_req_tag_o;
    logic [SID_W-1:0]      out_req_sid_o;

    logic                  out_rsp_valid_i;
    logic [SID_W-1:0]      out_rsp_sid_i;
    logic [TAG_WIDTH-1:0]  out_rsp_tag_i;
    logic [DATA_WIDTH-1:0] out_rsp_data_i;

    logic [NUM_REQS-1:0]   rsp_valid_o;
    logic [TAG_WIDTH-1:0]  rsp_tag_o;
    logic [DATA_WIDTH-1:0] rsp_data_o;

    modport slave (
        input  req_valid_i, req_rw_i, req_flush_i, req_addr_i,
        input  req_data_i, req_byteen_i, req_tag_i,
        output req_ready_o,
        output out_req_valid_o, out_req_rw_o, out_req_flush_o,
        output out_req_addr_o, out_req_data_o, out_req_byteen_o,
        output out_req_tag_o, out_req_sid_o,
        input  out_req_ready_i,
        input  out_rsp_valid_i, out_rsp_sid_i, out_rsp_tag_i, out_rsp_data_i,
        output rsp_valid_o, rsp_tag_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_rw_i, req_flush_i, req_addr_i,
        output req_data_i, req_byteen_i, req_tag_i,
        input  req_ready_o,
        input  out_req_valid_o, out_req_rw_o, out_req_flush_o,
        input  out_req_addr_o, out_req_data_o, out_req_byteen_o,
        input  out_req_tag_o, out_req_sid_o,
        output out_req_ready_i,
        output out_rsp_valid_i, out_rsp_sid_i, out_rsp_tag_i, out_rsp_data_i,
        input  rsp_valid_o, rsp_tag_o, rsp_data_o
    );
endinterface

// File: rtl/vx_hpdcache_req_sched.sv
// Round-robin sharing of the HPDCache core port among Vortex requesters,
// with sid-based response routing, in-flight limiting and flush sequencing.
module vx_hpdcache_req_sched #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    vx_hpdcache_req_sched_if.slave bus,
    output logic                   busy_o
);
    localparam int SID_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FWAIT = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
    localparam logic [SID_W-1:0] LAST    = SID_W'(NUM_REQS - 1);

    function automatic logic [SID_W-1:0] f_next(input logic [SID_W-1:0] idx);
        return (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SID_W-1:0] r_rr_ptr;
    logic [SID_W-1:0] w_rr_nxt;
    logic [CNT_W-1:0] r_pend;
    logic [SID_W-1:0] r_owner;

    logic                  r_out_valid;
    logic                  r_out_rw;
    logic                  r_out_flush;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [BE_W-1:0]       r_out_byteen;
    logic [TAG_WIDTH-1:0]  r_out_tag;
    logic [SID_W-1:0]      r_out_sid;

    logic [NUM_REQS-1:0]   w_elig;
    logic                  w_found;
    logic [SID_W-1:0]      w_win;
    logic                  w_win_flush;
    logic                  w_can_load;
    logic                  w_drain_go;
    logic                  w_owner_rsp;
    logic [NUM_REQS-1:0]   w_ready;
    logic                  w_load;
    logic                  w_load_flush;
    logic                  w_set_owner;
    logic                  w_inc;
    logic                  w_dec;
    logic [SID_W-1:0]      w_sel_idx;
    logic                  w_sel_rw;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [BE_W-1:0]       w_sel_byteen;
    logic [TAG_WIDTH-1:0]  w_sel_tag;

    // Reads wait for a free pending slot; writes and flushes never do.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_elig[i] = bus.req_valid_i[i]
                      & (bus.req_flush_i[i] | bus.req_rw_i[i]
                         | (r_pend < MAX_CNT));
        end
    end

    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        v_idx   = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQS) v_idx = v_idx - NUM_REQS;
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_win   = SID_W'(v_idx);
            end
        end
    end

    assign w_win_flush = bus.req_flush_i[w_win];
    assign w_can_load  = !r_out_valid || bus.out_req_ready_i;
    assign w_drain_go  = (r_pend == '0) && !r_out_valid
                       && bus.req_valid_i[r_owner];
    assign w_owner_rsp = bus.out_rsp_valid_i
                       && (bus.out_rsp_sid_i == r_owner);
    assign w_sel_idx   = (r_state == DRAIN) ? r_owner : w_win;

    always_comb begin
        w_sel_rw     = 1'b0;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_sel_byteen = '0;
        w_sel_tag    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_sel_idx == SID_W'(i)) begin
                w_sel_rw     = bus.req_rw_i[i];
                w_sel_addr   = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data   = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_byteen = bus.req_byteen_i[i*BE_W +: BE_W];
                w_sel_tag    = bus.req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            if (w_set_owner) r_owner <= w_win;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_found && w_win_flush) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!bus.req_valid_i[r_owner]) w_state_nxt = RUN;
                else if (w_drain_go)           w_state_nxt = FWAIT;
            end
            FWAIT: begin
                if (w_owner_rsp) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_ready      = '0;
        w_load       = 1'b0;
        w_load_flush = 1'b0;
        w_set_owner  = 1'b0;
        w_rr_nxt     = r_rr_ptr;
        unique case (r_state)
            RUN: begin
                if (w_found && w_win_flush) begin
                    w_set_owner = 1'b1;
                end else if (w_found && w_can_load) begin
                    w_ready[w_win] = 1'b1;
                    w_load         = 1'b1;
                    w_rr_nxt       = f_next(w_win);
                end
            end
            DRAIN: begin
                if (w_drain_go) begin
                    w_ready[r_owner] = 1'b1;
                    w_load           = 1'b1;
                    w_load_flush     = 1'b1;
                end
            end
            FWAIT: begin
                if (w_owner_rsp) w_rr_nxt = f_next(r_owner);
            end
            default: ;
        endcase
    end

    assign w_inc = w_load && (w_load_flush || !w_sel_rw);
    assign w_dec = bus.out_rsp_valid_i;

    // Stray responses at zero are absorbed rather than wrapping the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_inc && !w_dec)
                r_pend <= r_pend + 1'b1;
            else if (!w_inc && w_dec && (r_pend != '0))
                r_pend <= r_pend - 1'b1;
            if (w_can_load) r_out_valid <= w_load;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_out_rw     <= w_load_flush ? 1'b0 : w_sel_rw;
            r_out_flush  <= w_load_flush;
            r_out_addr   <= w_sel_addr;
            r_out_data   <= w_sel_data;
            r_out_byteen <= w_sel_byteen;
            r_out_tag    <= w_sel_tag;
            r_out_sid    <= w_sel_idx;
        end
    end

    assign bus.req_ready_o      = w_ready;
    assign bus.out_req_valid_o  = r_out_valid;
    assign bus.out_req_rw_o     = r_out_rw;
    assign bus.out_req_flush_o  = r_out_flush;
    assign bus.out_req_addr_o   = r_out_addr;
    assign bus.out_req_data_o   = r_out_data;
    assign bus.out_req_byteen_o = r_out_byteen;
    assign bus.out_req_tag_o    = r_out_tag;
    assign bus.out_req_sid_o    = r_out_sid;

    always_comb begin
        bus.rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.rsp_valid_o[i] = bus.out_rsp_valid_i
                               && (bus.out_rsp_sid_i == SID_W'(i));
        end
    end

    assign bus.rsp_tag_o  = bus.out_rsp_tag_i;
    assign bus.rsp_data_o = bus.out_rsp_data_i;

    assign busy_o = (r_state != RUN) || (r_pend != '0) || r_out_valid;

endmodule

// File: tb/tb_vx_hpdcache_req_sched.sv
// Directed bench for vx_hpdcache_req_sched: arbitration, backpressure,
// pending limit, flush sequencing and reset behaviour.
module tb_vx_hpdcache_req_sched;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_FWAIT = 2'd2;

    logic clk;
    logic reset;
    logic busy;
    int   checks;
    int   errors;

    vx_hpdcache_req_sched_if #(
        .NUM_REQS(4), .ADDR_WIDTH(32), .DATA_WIDTH(128), .TAG_WIDTH(8)
    ) bus ();

    vx_hpdcache_req_sched #(
        .NUM_REQS(4), .ADDR_WIDTH(32), .DATA_WIDTH(128),
        .TAG_WIDTH(8), .MAX_PENDING(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic rw,
                           input logic fl, input logic [31:0] a,
                           input logic [7:0] t);
        bus.req_valid_i[i]             = v;
        bus.req_rw_i[i]                = rw;
        bus.req_flush_i[i]             = fl;
        bus.req_addr_i[i*32 +: 32]     = a;
        bus.req_data_i[i*128 +: 128]   = {4{a}};
        bus.req_byteen_i[i*16 +: 16]   = 16'hFFFF;
        bus.req_tag_i[i*8 +: 8]        = t;
    endtask

    task automatic rsp(input logic v, input logic [1:0] sid,
                       input logic [7:0] t);
        bus.out_rsp_valid_i = v;
        bus.out_rsp_sid_i   = sid;
        bus.out_rsp_tag_i   = t;
        bus.out_rsp_data_i  = {16{t}};
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", bus.out_req_valid_o);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        checks++;
        if (dut.r_pend !== 4'd0) begin
            errors++;
            $display("FAIL reset_pend got %0d exp 0", dut.r_pend);
        end
        checks++;
        if (dut.r_state !== S_RUN || bus.req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %0d/%b exp 0/0000",
                     dut.r_state, bus.req_ready_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        logic [1:0] esid;
        for (int i = 0; i < 4; i++) set_req(i, 1, 1, 0, 32'h100 + i, 8'h10);
        bus.out_req_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp = 4'b0001 << (k % 4);
            checks++;
            if (bus.req_ready_o !== exp) begin
                errors++;
                $display("FAIL rr_ready k=%0d got %b exp %b",
                         k, bus.req_ready_o, exp);
            end
            if (k > 0) begin
                esid = 2'((k - 1) % 4);
                checks++;
                if (bus.out_req_valid_o !== 1'b1 || bus.out_req_sid_o !== esid
                    || bus.out_req_addr_o !== 32'h100 + 32'(esid)) begin
                    errors++;
                    $display("FAIL rr_out k=%0d got v%b sid%0d exp v1 sid%0d",
                             k, bus.out_req_valid_o, bus.out_req_sid_o, esid);
                end
            end
            cyc();
        end
        checks++;
        if (bus.out_req_valid_o !== 1'b1 || bus.out_req_sid_o !== 2'd0) begin
            errors++;
            $display("FAIL rr_wrap got v%b sid%0d exp v1 sid0",
                     bus.out_req_valid_o, bus.out_req_sid_o);
        end
        for (int i = 0; i < 4; i++) set_req(i, 0, 0, 0, 32'h0, 8'h0);
        cyc();
        checks++;
        if (bus.out_req_valid_o !== 1'b0 || dut.r_pend !== 4'd0) begin
            errors++;
            $display("FAIL rr_drain got v%b pend%0d exp v0 pend0",
                     bus.out_req_valid_o, dut.r_pend);
        end
    endtask

    task automatic test_backpressure();
        bus.out_req_ready_i = 1'b0;
        set_req(2, 1, 0, 0, 32'h222, 8'h5A);
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL bp_accept got %b exp 0100", bus.req_ready_o);
        end
        cyc();
        set_req(2, 0, 0, 0, 32'h0, 8'h0);
        set_req(0, 1, 1, 0, 32'h300, 8'h30);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.out_req_valid_o !== 1'b1 || bus.out_req_sid_o !== 2'd2
                || bus.out_req_addr_o !== 32'h222 || bus.out_req_tag_o !== 8'h5A
                || bus.out_req_rw_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d got v%b sid%0d addr%h tag%h",
                         c, bus.out_req_valid_o, bus.out_req_sid_o,
                         bus.out_req_addr_o, bus.out_req_tag_o);
            end
            checks++;
            if (bus.req_ready_o !== 4'b0000 || dut.r_pend !== 4'd1) begin
                errors++;
                $display("FAIL bp_stall c=%0d got rdy%b pend%0d exp 0000/1",
                         c, bus.req_ready_o, dut.r_pend);
            end
            cyc();
        end
        bus.out_req_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release got %b exp 0001", bus.req_ready_o);
        end
        cyc();
        set_req(0, 0, 0, 0, 32'h0, 8'h0);
        #1;
        checks++;
        if (bus.out_req_sid_o !== 2'd0 || dut.r_pend !== 4'd1) begin
            errors++;
            $display("FAIL bp_next got sid%0d pend%0d exp sid0 pend1",
                     bus.out_req_sid_o, dut.r_pend);
        end
        rsp(1, 2'd2, 8'h5A);
        #1;
        checks++;
        if (bus.rsp_valid_o !== 4'b0100 || bus.rsp_tag_o !== 8'h5A) begin
            errors++;
            $display("FAIL bp_rsp got %b tag%h exp 0100 tag5a",
                     bus.rsp_valid_o, bus.rsp_tag_o);
        end
        cyc();
        rsp(0, 2'd0, 8'h0);
        #1;
        checks++;
        if (dut.r_pend !== 4'd0 || bus.rsp_valid_o !== 4'b0000) begin
            errors++;
            $display("FAIL bp_pend got pend%0d rsp%b exp 0/0000",
                     dut.r_pend, bus.rsp_valid_o);
        end
    endtask

    task automatic test_pending_limit();
        set_req(0, 1, 0, 0, 32'h400, 8'h40);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (bus.req_ready_o !== 4'b0001) begin
                errors++;
                $display("FAIL pl_fill k=%0d got %b exp 0001",
                         k, bus.req_ready_o);
            end
            cyc();
        end
        set_req(1, 1, 1, 0, 32'h410, 8'h41);
        #1;
        checks++;
        if (dut.r_pend !== 4'd8 || bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL pl_full got pend%0d rdy%b exp 8/0010",
                     dut.r_pend, bus.req_ready_o);
        end
        cyc();
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL pl_write got %b exp 0010", bus.req_ready_o);
        end
        rsp(1, 2'd0, 8'h40);
        cyc();
        rsp(0, 2'd0, 8'h0);
        set_req(1, 0, 0, 0, 32'h0, 8'h0);
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001 || dut.r_pend !== 4'd7) begin
            errors++;
            $display("FAIL pl_resume got rdy%b pend%0d exp 0001/7",
                     bus.req_ready_o, dut.r_pend);
        end
        cyc();
        set_req(0, 0, 0, 0, 32'h0, 8'h0);
        for (int k = 0; k < 8; k++) begin
            rsp(1, 2'd0, 8'h40);
            cyc();
        end
        rsp(0, 2'd0, 8'h0);
        #1;
        checks++;
        if (dut.r_pend !== 4'd0) begin
            errors++;
            $display("FAIL pl_empty got %0d exp 0", dut.r_pend);
        end
    endtask

    task automatic test_simultaneous();
        set_req(0, 1, 0, 0, 32'h480, 8'h48);
        cyc();
        rsp(1, 2'd0, 8'h48);
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001 || dut.r_pend !== 4'd1) begin
            errors++;
            $display("FAIL sim_pre got rdy%b pend%0d exp 0001/1",
                     bus.req_ready_o, dut.r_pend);
        end
        cyc();
        rsp(0, 2'd0, 8'h0);
        set_req(0, 0, 0, 0, 32'h0, 8'h0);
        #1;
        checks++;
        if (dut.r_pend !== 4'd1) begin
            errors++;
            $display("FAIL sim_pend got %0d exp 1", dut.r_pend);
        end
        rsp(1, 2'd0, 8'h48);
        cyc();
        rsp(0, 2'd0, 8'h0);
    endtask

    task automatic test_flush();
        for (int r = 0; r < 3; r++) begin
            set_req(r, 1, 0, 0, 32'h500 + r, 8'h50);
            #1;
            checks++;
            if (bus.req_ready_o !== 4'(1 << r)) begin
                errors++;
                $display("FAIL fl_read r=%0d got %b", r, bus.req_ready_o);
            end
            cyc();
            set_req(r, 0, 0, 0, 32'h0, 8'h0);
        end
        set_req(3, 1, 0, 1, 32'h5F0, 8'h5F);
        set_req(0, 1, 1, 0, 32'h600, 8'h60);
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL fl_detect got %b exp 0000", bus.req_ready_o);
        end
        cyc();
        checks++;
        if (dut.r_state !== S_DRAIN || dut.r_pend !== 4'd3) begin
            errors++;
            $display("FAIL fl_drain got st%0d pend%0d exp 1/3",
                     dut.r_state, dut.r_pend);
        end
        for (int r = 0; r < 3; r++) begin
            #1;
            checks++;
            if (bus.req_ready_o !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL fl_block r=%0d got rdy%b busy%b",
                         r, bus.req_ready_o, busy);
            end
            rsp(1, 2'(r), 8'h50);
            cyc();
            rsp(0, 2'd0, 8'h0);
        end
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b1000) begin
            errors++;
            $display("FAIL fl_issue got %b exp 1000", bus.req_ready_o);
        end
        cyc();
        set_req(3, 0, 0, 0, 32'h0, 8'h0);
        #1;
        checks++;
        if (bus.out_req_valid_o !== 1'b1 || bus.out_req_flush_o !== 1'b1
            || bus.out_req_rw_o !== 1'b0 || bus.out_req_sid_o !== 2'd3
            || dut.r_state !== S_FWAIT) begin
            errors++;
            $display("FAIL fl_out got v%b f%b rw%b sid%0d st%0d",
                     bus.out_req_valid_o, bus.out_req_flush_o,
                     bus.out_req_rw_o, bus.out_req_sid_o, dut.r_state);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.req_ready_o !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL fl_wait c=%0d got rdy%b busy%b",
                         c, bus.req_ready_o, busy);
            end
            cyc();
        end
        rsp(1, 2'd3, 8'h5F);
        #1;
        checks++;
        if (bus.rsp_valid_o !== 4'b1000) begin
            errors++;
            $display("FAIL fl_rsp got %b exp 1000", bus.rsp_valid_o);
        end
        cyc();
        rsp(0, 2'd0, 8'h0);
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001 || dut.r_state !== S_RUN
            || dut.r_pend !== 4'd0) begin
            errors++;
            $display("FAIL fl_done got rdy%b st%0d pend%0d exp 0001/0/0",
                     bus.req_ready_o, dut.r_state, dut.r_pend);
        end
        cyc();
        set_req(0, 0, 0, 0, 32'h0, 8'h0);
        cyc();
    endtask

    task automatic test_reset_fwait();
        bus.out_req_ready_i = 1'b0;
        set_req(1, 1, 0, 1, 32'h700, 8'h70);
        cyc();
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0010) begin
            errors++;
            $display("FAIL rf_issue got %b exp 0010", bus.req_ready_o);
        end
        cyc();
        set_req(1, 0, 0, 0, 32'h0, 8'h0);
        checks++;
        if (dut.r_state !== S_FWAIT || bus.out_req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rf_fwait got st%0d v%b exp 2/1",
                     dut.r_state, bus.out_req_valid_o);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_req_valid_o !== 1'b0 || busy !== 1'b0
            || dut.r_pend !== 4'd0 || dut.r_state !== S_RUN) begin
            errors++;
            $display("FAIL rf_reset got v%b busy%b pend%0d st%0d exp 0/0/0/0",
                     bus.out_req_valid_o, busy, dut.r_pend, dut.r_state);
        end
        rsp(1, 2'd3, 8'h77);
        #1;
        checks++;
        if (bus.rsp_valid_o !== 4'b1000) begin
            errors++;
            $display("FAIL rf_stray_route got %b exp 1000", bus.rsp_valid_o);
        end
        cyc();
        rsp(0, 2'd0, 8'h0);
        #1;
        checks++;
        if (dut.r_pend !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rf_stray_pend got pend%0d busy%b exp 0/0",
                     dut.r_pend, busy);
        end
        set_req(0, 1, 1, 0, 32'h800, 8'h80);
        set_req(1, 1, 1, 0, 32'h810, 8'h81);
        bus.out_req_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL rf_rrptr got %b exp 0001", bus.req_ready_o);
        end
        cyc();
        set_req(0, 0, 0, 0, 32'h0, 8'h0);
        set_req(1, 0, 0, 0, 32'h0, 8'h0);
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_valid_i     = '0;
        bus.req_rw_i        = '0;
        bus.req_flush_i     = '0;
        bus.req_addr_i      = '0;
        bus.req_data_i      = '0;
        bus.req_byteen_i    = '0;
        bus.req_tag_i       = '0;
        bus.out_req_ready_i = 1'b0;
        rsp(0, 2'd0, 8'h0);
        cyc();
        cyc();
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_pending_limit();
        test_simultaneous();
        test_flush();
        test_reset_fwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_hpdcache_req_sched.md
# vx_hpdcache_req_sched

Shares the single HPDCache core request port among `NUM_REQS` Vortex requesters (LSU lanes / sockets) ahead of the core-interface adapter. Grants requests round-robin through a one-entry registered output stage and tags each with the requester index as the HPDCache source ID (sid). Routes responses back by sid and bounds in-flight responses. Sequences flushes: drains all outstanding reads, issues the flush alone, and blocks other traffic until the flush completes.

## Interface
- `NUM_REQS`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 32: word-address width, passed through unchanged.
- `DATA_WIDTH`, 128: data width; byte-enable width is `DATA_WIDTH/8`.
- `TAG_WIDTH`, 8: core request tag width.
- `MAX_PENDING`, 8: maximum outstanding response-bearing requests (reads + flush).
- `SID_W` (derived): max(1, clog2(`NUM_REQS`)).
- `clk` in 1: clock; the block uses this single clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid_i` in `NUM_REQS`: per-requester request valid.
- `req_rw_i` in `NUM_REQS`: 1 = write (no response), 0 = read.
- `req_flush_i` in `NUM_REQS`: flush request; overrides `rw`.
- `req_addr_i` in `NUM_REQS*ADDR_WIDTH`: packed addresses, requester 0 in the LSBs.
- `req_data_i` in `NUM_REQS*DATA_WIDTH`: packed write data.
- `req_byteen_i` in `NUM_REQS*DATA_WIDTH/8`: packed byte enables.
- `req_tag_i` in `NUM_REQS*TAG_WIDTH`: packed tags.
- `req_ready_o` out `NUM_REQS`: one-hot accept strobe.
- `out_req_valid_o` out 1: request valid toward the adapter.
- `out_req_ready_i` in 1: adapter ready.
- `out_req_rw_o`, `out_req_flush_o`, `out_req_addr_o`, `out_req_data_o`, `out_req_byteen_o`, `out_req_tag_o` out: registered copy of the granted request.
- `out_req_sid_o` out `SID_W`: granted requester index.
- `out_rsp_valid_i` in 1: HPDCache response valid. There is no backpressure.
- `out_rsp_sid_i` in `SID_W`: response source ID.
- `out_rsp_tag_i` in `TAG_WIDTH`: response tag.
- `out_rsp_data_i` in `DATA_WIDTH`: response data.
- `rsp_valid_o` out `NUM_REQS`: per-requester response valid.
- `rsp_tag_o` out `TAG_WIDTH`: response tag, broadcast to all requesters.
- `rsp_data_o` out `DATA_WIDTH`: response data, broadcast to all requesters.
- `busy_o` out 1: high when state ≠ RUN, or `pend_cnt` ≠ 0, or `out_req_valid_o` = 1.

## Operation
- **State and reset.** Internal state is `state`, `rr_ptr`, `pend_cnt` and `flush_owner`. Reset values: `state`=RUN, `rr_ptr`=0, `pend_cnt`=0, `out_req_valid_o`=0, `busy_o`=0.
- **Output stage.**
  - The stage can load when `!out_req_valid_o || out_req_ready_i`.
  - When a load occurs, all `out_req_*` fields register the winner's fields and `out_req_sid_o` = winner index.
  - Otherwise the fields hold stable while `out_req_valid_o` is high.
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` and (`req_flush_i[i]`, or `req_rw_i[i]`, or `pend_cnt` < `MAX_PENDING`).
- **Winner selection.** The winner is the first eligible requester scanning from `rr_ptr` upward, modulo `NUM_REQS`.
- **RUN state.**
  - If the winner is a non-flush request and the stage can load: assert `req_ready_o[winner]`, load the stage, set `rr_ptr` = winner+1 mod `NUM_REQS`.
  - If the winner is a flush: do not accept it. Set `flush_owner` = winner and go to DRAIN.
- **DRAIN state.**
  - `req_ready_o` = 0 for all requesters.
  - When `pend_cnt`=0, `out_req_valid_o`=0 and `req_valid_i[flush_owner]` is still high: accept the flush into the stage (`out_req_flush_o`=1, `rw`=0) and go to FWAIT.
  - If the owner drops valid: return to RUN.
- **FWAIT state.**
  - `req_ready_o` = 0 for all requesters.
  - On `out_rsp_valid_i` with sid = `flush_owner`: return to RUN and set `rr_ptr` = `flush_owner`+1.
- **Pending counter.**
  - `pend_cnt` +1 when a read or flush is accepted into the stage.
  - `pend_cnt` −1 on `out_rsp_valid_i`.
  - Both in the same cycle: unchanged.
  - A response arriving while `pend_cnt`=0 leaves it at 0; there is no underflow.
  - Writes never count.
- **Response routing.**
  - `rsp_valid_o[i]` = `out_rsp_valid_i && out_rsp_sid_i==i`.
  - `rsp_data_o` and `rsp_tag_o` are pass-throughs of the response inputs.
  - A sid ≥ `NUM_REQS` is dropped, but it still decrements `pend_cnt`.

## Timing
- `req_ready_o` is combinational from `req_valid_i`, `state`, `pend_cnt`, `out_req_ready_i` and `out_req_valid_o`.
- An accept in cycle N gives `out_req_valid_o` in cycle N+1.
- Throughput is 1 request/cycle with `out_req_ready_i` held high.
- Responses are combinational, 0-cycle latency from the response inputs to `rsp_*`.
- Flush latency: drain time + 1 cycle issue + the HPDCache flush response.
- A flush is accepted in the cycle after `pend_cnt` reaches 0 with the stage empty.
- Reset asserted mid-flush or mid-transaction: at the next edge all state returns to its reset value and the registered request is discarded.

## Test plan
- **Round-robin.** All 4 requesters issue continuous writes, `out_req_ready_i`=1 → output sids cycle 0,1,2,3,0 with one request per cycle; each request appears one cycle after its `req_ready_o`.
- **Backpressure.** Requester 2 read, `out_req_ready_i`=0 for 3 cycles → output fields stable for those 3 cycles, no further `req_ready_o`, single transfer on release; `pend_cnt`=1 until the response with sid=2, then `rsp_valid_o`=4'b0100.
- **Pending limit.** 8 reads outstanding (`MAX_PENDING`=8) with writes pending on requester 1 → reads stalled, writes still accepted; one response → next read accepted the following cycle.
- **Flush sequencing.** 3 reads in flight, requester 3 raises flush → state DRAIN, no grants until 3 responses return; flush issued with `out_req_flush_o`=1 and sid=3; other requesters blocked until the response with sid=3; then the next grant goes to requester 0.
- **Simultaneous accept and response.** Read accept and response in the same cycle → `pend_cnt` unchanged.
- **Reset and stray responses.** Reset pulsed during FWAIT → all outputs at reset values on the next cycle and state RUN; a response with sid=3 while `pend_cnt`=0 → `pend_cnt` stays 0.
